// File: rtl/btn_evt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : btn_evt_pkg
//  Purpose  : Shared event codes, channel FSM state encodings and a width
//             helper for the button event controller.
//  Revision : 1.0  initial release
// ============================================================================
package btn_evt_pkg;

    // Event codes presented on evt_code.
    localparam logic [1:0] EVT_NONE   = 2'd0;
    localparam logic [1:0] EVT_SHORT  = 2'd1;
    localparam logic [1:0] EVT_LONG   = 2'd2;
    localparam logic [1:0] EVT_DOUBLE = 2'd3;

    // Per-channel press classifier states.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRESSED  = 3'd1,
        S_LHELD    = 3'd2,
        S_WAIT_DBL = 3'd3,
        S_PRESS2   = 3'd4
    } state_t;

    // Channel index width; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_press_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : btn_press_fsm
//  Purpose  : Classifies one debounced button level into SHORT / LONG /
//             DOUBLE events and parks the result in a one-deep pending slot.
//  Ports    : clk, rst_n   clock, async active-low reset
//             lvl          debounced level, 1 = pressed
//             clr          grant from the arbiter, empties the pending slot
//             pend, code   pending flag and its event code
//             drop         an event was raised while the slot was full
//  Revision : 1.0  initial release
// ============================================================================
module btn_press_fsm
    import btn_evt_pkg::*;
#(
    parameter int LONG_CYC = 1000,
    parameter int DBL_CYC  = 250,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lvl,
    input  logic       clr,
    output logic       pend,
    output logic [1:0] code,
    output logic       drop
);

    localparam logic [CNT_W-1:0] C_LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] C_DBL_LAST  = CNT_W'(DBL_CYC - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

    logic             r_prev;
    logic             w_rise;
    logic             w_fall;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_raise;
    logic [1:0]       w_raise_code;
    logic             r_pend;
    logic [1:0]       r_code;

    assign w_rise = lvl & ~r_prev;
    assign w_fall = ~lvl & r_prev;

    always_comb begin
        w_state_nxt  = r_state;
        w_raise      = 1'b0;
        w_raise_code = EVT_NONE;
        case (r_state)
            S_IDLE: begin
                if (w_rise) w_state_nxt = S_PRESSED;
            end
            S_PRESSED: begin
                if ((r_cnt == C_LONG_LAST) && lvl) begin
                    w_raise      = 1'b1;
                    w_raise_code = EVT_LONG;
                    w_state_nxt  = S_LHELD;
                end else if (w_fall) begin
                    w_state_nxt  = S_WAIT_DBL;
                end
            end
            S_LHELD: begin
                if (w_fall) w_state_nxt = S_IDLE;
            end
            S_WAIT_DBL: begin
                if (w_rise) begin
                    w_state_nxt  = S_PRESS2;
                end else if (r_cnt == C_DBL_LAST) begin
                    w_raise      = 1'b1;
                    w_raise_code = EVT_SHORT;
                    w_state_nxt  = S_IDLE;
                end
            end
            S_PRESS2: begin
                // Second press is reported on release regardless of length.
                if (w_fall) begin
                    w_raise      = 1'b1;
                    w_raise_code = EVT_DOUBLE;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A grant in the same cycle frees the slot, so the new event is kept.
    assign drop = w_raise & r_pend & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Level assumed high so a button held through reset gives no rise.
            r_prev  <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_code  <= EVT_NONE;
        end else begin
            r_prev  <= lvl;
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != C_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_raise && (!r_pend || clr)) begin
                r_pend <= 1'b1;
                r_code <= w_raise_code;
            end else if (clr) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign pend = r_pend;
    assign code = r_code;

endmodule
`default_nettype wire

// File: rtl/button_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : button_event_ctrl
//  Purpose  : Per-channel press classification plus a round-robin arbiter
//             that serialises events onto one valid/ready stream.
//  Ports    : clk, rst_n            clock, async active-low reset
//             btn_lvl[NUM_BTN]      debounced levels, 1 = pressed
//             evt_valid/evt_ready   output handshake
//             evt_btn, evt_code     channel index and event code
//             overflow, ovf_clr     sticky lost-event flag and its clear
//  Revision : 1.0  initial release
// ============================================================================
module button_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter  int NUM_BTN  = 4,
    parameter  int LONG_CYC = 1000,
    parameter  int DBL_CYC  = 250,
    parameter  int CNT_W    = 16,
    localparam int IDX_W    = idx_width(NUM_BTN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_lvl,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [IDX_W-1:0]   evt_btn,
    output logic [1:0]         evt_code,
    output logic               overflow,
    input  logic               ovf_clr
);

    logic [NUM_BTN-1:0]      w_pend;
    logic [NUM_BTN-1:0]      w_drop;
    logic [NUM_BTN-1:0]      w_clr;
    logic [NUM_BTN-1:0][1:0] w_code;

    logic                    w_load;
    logic                    w_found;
    logic [IDX_W-1:0]        w_gnt;
    logic [IDX_W-1:0]        w_scan;
    logic [IDX_W-1:0]        w_rr_nxt;

    logic                    r_valid;
    logic [IDX_W-1:0]        r_btn;
    logic [1:0]              r_code;
    logic [IDX_W-1:0]        r_rr;
    logic                    r_ovf;

    generate
        for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
            assign w_clr[g] = w_load & w_found & (w_gnt == IDX_W'(g));

            btn_press_fsm #(
                .LONG_CYC (LONG_CYC),
                .DBL_CYC  (DBL_CYC),
                .CNT_W    (CNT_W)
            ) u_fsm (
                .clk   (clk),
                .rst_n (rst_n),
                .lvl   (btn_lvl[g]),
                .clr   (w_clr[g]),
                .pend  (w_pend[g]),
                .code  (w_code[g]),
                .drop  (w_drop[g])
            );
        end
    endgenerate

    // Output slot is free when empty or being consumed this cycle.
    assign w_load = !r_valid || evt_ready;

    // First pending channel at or after the round-robin pointer, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_scan  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_scan = IDX_W'((int'(r_rr) + i) % NUM_BTN);
            if (!w_found && w_pend[w_scan]) begin
                w_found = 1'b1;
                w_gnt   = w_scan;
            end
        end
    end

    assign w_rr_nxt = (w_gnt == IDX_W'(NUM_BTN - 1)) ? '0 : w_gnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_btn   <= '0;
            r_code  <= EVT_NONE;
            r_rr    <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_load) begin
                if (w_found) begin
                    r_valid <= 1'b1;
                    r_btn   <= w_gnt;
                    r_code  <= w_code[w_gnt];
                    r_rr    <= w_rr_nxt;
                end else begin
                    r_valid <= 1'b0;
                end
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (|w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign evt_valid = r_valid;
    assign evt_btn   = r_btn;
    assign evt_code  = r_code;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_button_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_event_ctrl
//  Purpose  : Directed self-checking bench for button_event_ctrl with
//             NUM_BTN=4, LONG_CYC=8, DBL_CYC=4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_button_event_ctrl;

    localparam int NUM_BTN  = 4;
    localparam int LONG_CYC = 8;
    localparam int DBL_CYC  = 4;
    localparam int CNT_W    = 16;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [3:0] btn_lvl   = 4'h0;
    logic       evt_ready = 1'b1;
    logic       ovf_clr   = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_btn;
    logic [1:0] evt_code;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    button_event_ctrl #(
        .NUM_BTN  (NUM_BTN),
        .LONG_CYC (LONG_CYC),
        .DBL_CYC  (DBL_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_lvl   (btn_lvl),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_btn   (evt_btn),
        .evt_code  (evt_code),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_evt(input string tag, input logic [1:0] b, input logic [1:0] c);
        chk({tag, "_valid"}, {7'd0, evt_valid}, 8'd1);
        chk({tag, "_btn"},   {6'd0, evt_btn},   {6'd0, b});
        chk({tag, "_code"},  {6'd0, evt_code},  {6'd0, c});
    endtask

    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, {7'd0, evt_valid}, 8'd0);
        end
    endtask

    // High 3 cycles, low 5: the WAIT_DBL timeout raises SHORT in the 8th
    // cycle, so on return the event sits in the pending slot.
    task automatic press_short(input logic [3:0] m);
        btn_lvl = btn_lvl | m;
        repeat (3) tick();
        btn_lvl = btn_lvl & ~m;
        repeat (5) tick();
    endtask

    initial begin
        #100000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_valid", {7'd0, evt_valid}, 8'd0);
        chk("rst_btn",   {6'd0, evt_btn},   8'd0);
        chk("rst_code",  {6'd0, evt_code},  8'd0);
        chk("rst_ovf",   {7'd0, overflow},  8'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // 1: SHORT on btn0, valid two cycles after the timeout cycle
        press_short(4'b0001);
        chk("t1_early", {7'd0, evt_valid}, 8'd0);
        tick();
        chk_evt("t1", 2'd0, 2'd1);
        tick();
        chk("t1_gone", {7'd0, evt_valid}, 8'd0);

        // 2: LONG on btn1 while held; release adds nothing
        btn_lvl = 4'b0010;
        repeat (9) tick();
        chk("t2_early", {7'd0, evt_valid}, 8'd0);
        tick();
        chk_evt("t2", 2'd1, 2'd2);
        btn_lvl = 4'b0000;
        quiet("t2_quiet", 10);

        // 3: DOUBLE on btn2, no SHORT follows
        btn_lvl = 4'b0100;
        tick(); tick();
        btn_lvl = 4'b0000;
        tick(); tick();
        btn_lvl = 4'b0100;
        tick(); tick();
        btn_lvl = 4'b0000;
        tick();
        chk("t3_early", {7'd0, evt_valid}, 8'd0);
        tick();
        chk_evt("t3", 2'd2, 2'd3);
        quiet("t3_quiet", 8);

        // 4: simultaneous raises from a reset pointer (rr=0)
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        press_short(4'hF);
        tick(); chk_evt("t4a_0", 2'd0, 2'd1);
        tick(); chk_evt("t4a_1", 2'd1, 2'd1);
        tick(); chk_evt("t4a_2", 2'd2, 2'd1);
        tick(); chk_evt("t4a_3", 2'd3, 2'd1);
        tick(); chk("t4a_end", {7'd0, evt_valid}, 8'd0);
        chk("t4a_ovf", {7'd0, overflow}, 8'd0);
        // Granting btn1 alone moves the pointer to 2
        press_short(4'b0010);
        tick(); chk_evt("t4_rr", 2'd1, 2'd1);
        tick(); chk("t4_rr_end", {7'd0, evt_valid}, 8'd0);
        press_short(4'hF);
        tick(); chk_evt("t4b_2", 2'd2, 2'd1);
        tick(); chk_evt("t4b_3", 2'd3, 2'd1);
        tick(); chk_evt("t4b_0", 2'd0, 2'd1);
        tick(); chk_evt("t4b_1", 2'd1, 2'd1);
        tick(); chk("t4b_end", {7'd0, evt_valid}, 8'd0);

        // 5: stalled consumer; first event in the output register, second
        //    in the pending slot, third has nowhere to go and is dropped
        evt_ready = 1'b0;
        press_short(4'b1000);
        tick();
        chk_evt("t5_first", 2'd3, 2'd1);
        press_short(4'b1000);
        chk_evt("t5_hold1", 2'd3, 2'd1);
        chk("t5_no_ovf", {7'd0, overflow}, 8'd0);
        press_short(4'b1000);
        chk_evt("t5_hold2", 2'd3, 2'd1);
        chk("t5_ovf", {7'd0, overflow}, 8'd1);
        evt_ready = 1'b1;
        tick();
        chk_evt("t5_second", 2'd3, 2'd1);
        tick();
        chk("t5_end", {7'd0, evt_valid}, 8'd0);
        chk("t5_sticky", {7'd0, overflow}, 8'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t5_clr", {7'd0, overflow}, 8'd0);

        // 6: async reset mid-press with an event in flight
        evt_ready = 1'b0;
        press_short(4'b0010);
        tick();
        chk_evt("t6_inflight", 2'd1, 2'd1);
        btn_lvl = 4'b0001;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {7'd0, evt_valid}, 8'd0);
        chk("t6_rst_btn",   {6'd0, evt_btn},   8'd0);
        chk("t6_rst_code",  {6'd0, evt_code},  8'd0);
        chk("t6_rst_ovf",   {7'd0, overflow},  8'd0);
        tick();
        tick();
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        quiet("t6_held", 12);
        btn_lvl = 4'b0000;
        quiet("t6_release", 8);
        press_short(4'b0001);
        tick();
        chk_evt("t6_new", 2'd0, 2'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
